// File: rtl/sd_block_loader.sv
// SD-card-to-RAM bulk loader: reads consecutive SD blocks through the byte handshake
// and packs them into DATA_W-bit RAM writes starting at a per-run base address.
module sd_block_loader #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 25,
  parameter int FIRST_BYTE_LSB = 1,
  parameter int SDHC           = 1
) (
  input  logic              clk50,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       sd_start_block,
  input  logic [ADDR_W-1:0] ram_base_addr,
  input  logic [ADDR_W-1:0] word_count,
  output logic              sd_rd,
  output logic              sd_continue,
  output logic [31:0]       sd_addr,
  input  logic [7:0]        sd_data,
  input  logic              sd_busy,
  input  logic              sd_hndshk_rdy,
  output logic              sd_hndshk_ack,
  input  logic [15:0]       sd_error,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  input  logic              ram_op_begun,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [15:0]       error_code,
  output logic [ADDR_W-1:0] words_written
);

  localparam int BPW = DATA_W / 8;

  typedef enum logic [3:0] {
    IDLE, WAIT_INIT, REQ_BLOCK, GET_BYTE, ACK_BYTE, WRITE, DRAIN, DONE, ERROR
  } state_t;

  state_t            state, state_nxt;
  logic [31:0]       start_block_q;
  logic [ADDR_W-1:0] base_q;
  logic [ADDR_W-1:0] count_q;
  logic [31:0]       block_idx;
  logic [2:0]        byte_cnt;
  logic [DATA_W-1:0] asm_q;
  logic              abort_q;
  logic [31:0]       blk_sum;
  logic [2:0]        lane;
  logic              last_byte;
  logic [ADDR_W-1:0] ww_inc;

  assign blk_sum     = start_block_q + block_idx;
  assign sd_addr     = (SDHC != 0) ? blk_sum : {blk_sum[22:0], 9'd0};
  assign lane        = (FIRST_BYTE_LSB != 0) ? byte_cnt : 3'(BPW - 1) - byte_cnt;
  assign last_byte   = (byte_cnt == 3'(BPW - 1));
  assign ww_inc      = words_written + ADDR_W'(1);
  assign ram_address = base_q + words_written;
  assign ram_data    = asm_q;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      start_block_q <= '0;
      base_q        <= '0;
      count_q       <= '0;
      block_idx     <= '0;
      byte_cnt      <= '0;
      asm_q         <= '0;
      words_written <= '0;
      error_code    <= '0;
      abort_q       <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE, ERROR: begin
          if (start) begin
            start_block_q <= sd_start_block;
            base_q        <= ram_base_addr;
            count_q       <= word_count;
            block_idx     <= '0;
            byte_cnt      <= '0;
            words_written <= '0;
            error_code    <= '0;
            abort_q       <= 1'b0;
          end
        end
        WAIT_INIT: begin
          if (!sd_busy && sd_error != 16'h0) error_code <= sd_error;
        end
        GET_BYTE: begin
          if (sd_hndshk_rdy) begin
            for (int i = 0; i < BPW; i++) begin
              if (lane == 3'(i)) asm_q[i*8 +: 8] <= sd_data;
            end
          end else if (!sd_busy) begin
            // Block ended: a partial word is dropped so the next block starts word-aligned.
            if (sd_error != 16'h0) begin
              error_code <= sd_error;
            end else begin
              block_idx <= block_idx + 32'd1;
              byte_cnt  <= '0;
            end
          end
        end
        ACK_BYTE: begin
          if (!sd_hndshk_rdy) byte_cnt <= last_byte ? 3'd0 : byte_cnt + 3'd1;
        end
        WRITE: begin
          if (ram_op_begun) words_written <= ww_inc;
        end
        default: ;
      endcase
      // Abort overrides any error code latched in the same cycle.
      if (abort && busy) begin
        abort_q    <= 1'b1;
        error_code <= 16'hFFFF;
      end
    end
  end

  always_comb begin
    state_nxt     = state;
    sd_rd         = 1'b0;
    sd_continue   = 1'b0;
    sd_hndshk_ack = 1'b0;
    ram_we        = 1'b0;
    busy          = !(state == IDLE || state == DONE || state == ERROR);
    done          = (state == DONE);
    error         = (state == ERROR);
    case (state)
      IDLE, DONE, ERROR: begin
        if (start) state_nxt = (word_count == '0) ? DONE : WAIT_INIT;
      end
      WAIT_INIT: begin
        if (abort)         state_nxt = ERROR;
        else if (!sd_busy) state_nxt = (sd_error == 16'h0) ? REQ_BLOCK : ERROR;
      end
      REQ_BLOCK: begin
        sd_rd       = 1'b1;
        sd_continue = (block_idx != 32'd0);
        if (abort)        state_nxt = ERROR;
        else if (sd_busy) state_nxt = GET_BYTE;
      end
      GET_BYTE: begin
        if (abort)              state_nxt = DRAIN;
        else if (sd_hndshk_rdy) state_nxt = ACK_BYTE;
        else if (!sd_busy)      state_nxt = (sd_error != 16'h0) ? ERROR : REQ_BLOCK;
      end
      ACK_BYTE: begin
        sd_hndshk_ack = 1'b1;
        if (abort)               state_nxt = DRAIN;
        else if (!sd_hndshk_rdy) state_nxt = last_byte ? WRITE : GET_BYTE;
      end
      WRITE: begin
        ram_we = 1'b1;
        if (abort)             state_nxt = DRAIN;
        else if (ram_op_begun) state_nxt = (ww_inc == count_q) ? DRAIN : GET_BYTE;
      end
      DRAIN: begin
        // Ack follows ready so the controller finishes its block and returns to idle.
        sd_hndshk_ack = sd_hndshk_rdy;
        if (!sd_busy && !sd_hndshk_rdy) state_nxt = (abort_q || abort) ? ERROR : DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_block_loader.sv
// Bench for sd_block_loader: a 16-bit LSB-first SDHC instance and a 32-bit MSB-first
// byte-addressed instance share one behavioural SD controller and RAM port model.
module tb_sd_block_loader;

  logic        clk50   = 1'b0;
  logic        reset_n = 1'b0;
  logic        sel     = 1'b0;
  logic        start   = 1'b0;
  logic        abort   = 1'b0;
  logic [31:0] blk     = 32'h0;
  logic [24:0] base    = 25'h0;
  logic [24:0] count   = 25'h0;
  logic [7:0]  sd_data = 8'h0;
  logic        sd_busy = 1'b0;
  logic        sd_hndshk_rdy = 1'b0;
  logic [15:0] sd_error = 16'h0;
  logic        ram_op_begun = 1'b0;
  logic        ram_en = 1'b1;

  logic        rd16, cont16, ack16, we16, busy16, done16, err16;
  logic [31:0] sdaddr16;
  logic [24:0] ra16, ww16;
  logic [15:0] rdat16, code16;
  logic        rd32, cont32, ack32, we32, busy32, done32, err32;
  logic [31:0] sdaddr32, rdat32;
  logic [24:0] ra32, ww32;
  logic [15:0] code32;

  logic        rd_m, cont_m, ack_m, we_m, busy_m, done_m, err_m;
  logic [31:0] sdaddr_m, rdat_m;
  logic [24:0] ra_m, ww_m;
  logic [15:0] code_m;

  int checks = 0;
  int errors = 0;
  int req_n = 0;
  int bytes_acked = 0;
  int stall_n = 0;
  int wr_n = 0;
  logic [31:0] req_addr_log [0:63];
  logic        req_cont_log [0:63];
  logic [24:0] wr_addr_log [0:1023];
  logic [31:0] wr_data_log [0:1023];

  sd_block_loader #(.DATA_W(16), .ADDR_W(25), .FIRST_BYTE_LSB(1), .SDHC(1)) dut16 (
    .clk50(clk50), .reset_n(reset_n), .start(start & ~sel), .abort(abort & ~sel),
    .sd_start_block(blk), .ram_base_addr(base), .word_count(count),
    .sd_rd(rd16), .sd_continue(cont16), .sd_addr(sdaddr16), .sd_data(sd_data),
    .sd_busy(sd_busy), .sd_hndshk_rdy(sd_hndshk_rdy), .sd_hndshk_ack(ack16),
    .sd_error(sd_error), .ram_we(we16), .ram_address(ra16), .ram_data(rdat16),
    .ram_op_begun(ram_op_begun), .busy(busy16), .done(done16), .error(err16),
    .error_code(code16), .words_written(ww16)
  );

  sd_block_loader #(.DATA_W(32), .ADDR_W(25), .FIRST_BYTE_LSB(0), .SDHC(0)) dut32 (
    .clk50(clk50), .reset_n(reset_n), .start(start & sel), .abort(abort & sel),
    .sd_start_block(blk), .ram_base_addr(base), .word_count(count),
    .sd_rd(rd32), .sd_continue(cont32), .sd_addr(sdaddr32), .sd_data(sd_data),
    .sd_busy(sd_busy), .sd_hndshk_rdy(sd_hndshk_rdy), .sd_hndshk_ack(ack32),
    .sd_error(sd_error), .ram_we(we32), .ram_address(ra32), .ram_data(rdat32),
    .ram_op_begun(ram_op_begun), .busy(busy32), .done(done32), .error(err32),
    .error_code(code32), .words_written(ww32)
  );

  assign rd_m     = sel ? rd32 : rd16;
  assign cont_m   = sel ? cont32 : cont16;
  assign ack_m    = sel ? ack32 : ack16;
  assign we_m     = sel ? we32 : we16;
  assign busy_m   = sel ? busy32 : busy16;
  assign done_m   = sel ? done32 : done16;
  assign err_m    = sel ? err32 : err16;
  assign sdaddr_m = sel ? sdaddr32 : sdaddr16;
  assign rdat_m   = sel ? rdat32 : {16'h0, rdat16};
  assign ra_m     = sel ? ra32 : ra16;
  assign ww_m     = sel ? ww32 : ww16;
  assign code_m   = sel ? code32 : code16;

  always #10 clk50 = ~clk50;

  // SD controller: 512 bytes per request, byte i = (i+1)*17, plus 64 on continued blocks.
  always begin : sd_model
    int   n;
    logic cont;
    @(negedge clk50);
    if (reset_n && rd_m) begin
      req_addr_log[req_n % 64] = sdaddr_m;
      req_cont_log[req_n % 64] = cont_m;
      cont = cont_m;
      req_n++;
      sd_busy = 1'b1;
      for (int i = 0; i < 512; i++) begin
        @(negedge clk50);
        if (!reset_n) break;
        sd_data = 8'((i + 1) * 17 + (cont ? 64 : 0));
        sd_hndshk_rdy = 1'b1;
        n = 0;
        do begin @(negedge clk50); n++; end while (!ack_m && reset_n && n < 1000);
        sd_hndshk_rdy = 1'b0;
        if (!reset_n) break;
        if (!ack_m) begin stall_n++; break; end
        n = 0;
        do begin @(negedge clk50); n++; end while (ack_m && reset_n && n < 1000);
        if (!reset_n) break;
        if (ack_m) begin stall_n++; break; end
        bytes_acked++;
      end
      @(negedge clk50);
      sd_busy = 1'b0;
      sd_hndshk_rdy = 1'b0;
    end
  end

  always begin : ram_model
    @(negedge clk50);
    if (ram_op_begun) begin
      ram_op_begun = 1'b0;
    end else if (reset_n && ram_en && we_m) begin
      wr_addr_log[wr_n % 1024] = ra_m;
      wr_data_log[wr_n % 1024] = rdat_m;
      wr_n++;
      ram_op_begun = 1'b1;
    end
  end

  typedef struct {
    bit          sel;
    logic [31:0] blk;
    logic [24:0] base;
    logic [24:0] count;
    logic [15:0] init_err;
    bit          e_done;
    bit          e_err;
    logic [15:0] e_code;
    int          e_words;
    int          e_nreq;
    logic [31:0] e_addr0;
    logic [31:0] e_addr_last;
    bit          e_cont_last;
    int          e_bytes;
    logic [24:0] e_wa0;
    logic [31:0] e_wd0;
    logic [24:0] e_wal;
    logic [31:0] e_wdl;
  } vec_t;

  vec_t vecs [5];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic start_run(input bit s, input logic [31:0] b, input logic [24:0] ba,
                           input logic [24:0] c);
    @(negedge clk50);
    sel   = s;
    blk   = b;
    base  = ba;
    count = c;
    start = 1'b1;
    @(negedge clk50);
    start = 1'b0;
  endtask

  task automatic wait_finish(input int limit);
    int n;
    n = 0;
    while (!(done_m || err_m) && n < limit) begin
      @(negedge clk50);
      n++;
    end
    check_output("finish_timeout", 32'(done_m || err_m), 32'd1);
  endtask

  task automatic apply_stimulus(input int idx, input vec_t v);
    int r0, b0, w0;
    r0 = req_n;
    b0 = bytes_acked;
    w0 = wr_n;
    sd_error = v.init_err;
    start_run(v.sel, v.blk, v.base, v.count);
    wait_finish(12000);
    check_output($sformatf("v%0d_done", idx), 32'(done_m), 32'(v.e_done));
    check_output($sformatf("v%0d_error", idx), 32'(err_m), 32'(v.e_err));
    check_output($sformatf("v%0d_code", idx), 32'(code_m), 32'(v.e_code));
    check_output($sformatf("v%0d_words", idx), 32'(ww_m), v.e_words);
    check_output($sformatf("v%0d_busy", idx), 32'(busy_m), 32'd0);
    check_output($sformatf("v%0d_nreq", idx), req_n - r0, v.e_nreq);
    check_output($sformatf("v%0d_bytes", idx), bytes_acked - b0, v.e_bytes);
    check_output($sformatf("v%0d_nwrites", idx), wr_n - w0, v.e_words);
    if (v.e_nreq > 0 && req_n > r0) begin
      check_output($sformatf("v%0d_addr0", idx), req_addr_log[r0 % 64], v.e_addr0);
      check_output($sformatf("v%0d_cont0", idx), 32'(req_cont_log[r0 % 64]), 32'd0);
      check_output($sformatf("v%0d_addr_last", idx), req_addr_log[(req_n - 1) % 64], v.e_addr_last);
      check_output($sformatf("v%0d_cont_last", idx), 32'(req_cont_log[(req_n - 1) % 64]),
                   32'(v.e_cont_last));
    end
    if (v.e_words > 0 && wr_n > w0) begin
      check_output($sformatf("v%0d_wa0", idx), 32'(wr_addr_log[w0 % 1024]), 32'(v.e_wa0));
      check_output($sformatf("v%0d_wd0", idx), wr_data_log[w0 % 1024], v.e_wd0);
      check_output($sformatf("v%0d_wal", idx), 32'(wr_addr_log[(wr_n - 1) % 1024]), 32'(v.e_wal));
      check_output($sformatf("v%0d_wdl", idx), wr_data_log[(wr_n - 1) % 1024], v.e_wdl);
    end
    sd_error = 16'h0;
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : main
    int n, r0, b0, w0;
    vecs[0] = '{1'b0, 32'd7, 25'h100, 25'd3, 16'h0, 1'b1, 1'b0, 16'h0, 3, 1,
                32'd7, 32'd7, 1'b0, 512, 25'h100, 32'h2211, 25'h102, 32'h6655};
    vecs[1] = '{1'b0, 32'd0, 25'h1FFFFFF, 25'd2, 16'h0, 1'b1, 1'b0, 16'h0, 2, 1,
                32'd0, 32'd0, 1'b0, 512, 25'h1FFFFFF, 32'h2211, 25'h0, 32'h4433};
    vecs[2] = '{1'b0, 32'd9, 25'h50, 25'd5, 16'h0042, 1'b0, 1'b1, 16'h0042, 0, 0,
                32'd0, 32'd0, 1'b0, 0, 25'h0, 32'h0, 25'h0, 32'h0};
    vecs[3] = '{1'b0, 32'd3, 25'h10, 25'd257, 16'h0, 1'b1, 1'b0, 16'h0, 257, 2,
                32'd3, 32'd4, 1'b1, 1024, 25'h10, 32'h2211, 25'h110, 32'h6251};
    vecs[4] = '{1'b1, 32'd2, 25'h20, 25'd129, 16'h0, 1'b1, 1'b0, 16'h0, 129, 2,
                32'h400, 32'h600, 1'b1, 1024, 25'h20, 32'h11223344, 25'hA0, 32'h51627384};

    reset_n = 1'b0;
    repeat (3) @(negedge clk50);
    check_output("rst_busy", 32'(busy_m), 32'd0);
    check_output("rst_done", 32'(done_m), 32'd0);
    check_output("rst_error", 32'(err_m), 32'd0);
    check_output("rst_code", 32'(code_m), 32'd0);
    check_output("rst_words", 32'(ww_m), 32'd0);
    check_output("rst_we", 32'(we_m), 32'd0);
    check_output("rst_rd", 32'(rd_m), 32'd0);
    check_output("rst_ack", 32'(ack_m), 32'd0);
    reset_n = 1'b1;
    @(negedge clk50);

    for (int k = 0; k < 5; k++) apply_stimulus(k, vecs[k]);

    // Abort while a write is pending and the RAM has not accepted it.
    b0 = bytes_acked;
    ram_en = 1'b0;
    start_run(1'b0, 32'd1, 25'h30, 25'd4);
    n = 0;
    while (!we_m && n < 200) begin @(negedge clk50); n++; end
    check_output("abort_reach_write", 32'(we_m), 32'd1);
    abort = 1'b1;
    @(negedge clk50);
    abort = 1'b0;
    check_output("abort_we_drop", 32'(we_m), 32'd0);
    check_output("abort_no_count", 32'(ww_m), 32'd0);
    ram_en = 1'b1;
    wait_finish(5000);
    check_output("abort_error", 32'(err_m), 32'd1);
    check_output("abort_done", 32'(done_m), 32'd0);
    check_output("abort_code", 32'(code_m), 32'h0000FFFF);
    check_output("abort_drained", bytes_acked - b0, 512);
    check_output("abort_sd_idle", 32'(sd_busy), 32'd0);

    // Zero-length run completes next cycle without touching the SD card.
    r0 = req_n;
    start_run(1'b0, 32'd5, 25'h0, 25'd0);
    check_output("zero_done", 32'(done_m), 32'd1);
    check_output("zero_error", 32'(err_m), 32'd0);
    check_output("zero_code", 32'(code_m), 32'd0);
    check_output("zero_busy", 32'(busy_m), 32'd0);
    repeat (5) @(negedge clk50);
    check_output("zero_no_rd", req_n - r0, 0);

    // A start pulse during a run must not disturb it.
    w0 = wr_n;
    start_run(1'b0, 32'd0, 25'h40, 25'd2);
    repeat (3) @(negedge clk50);
    check_output("ign_busy_before", 32'(busy_m), 32'd1);
    start_run(1'b0, 32'd0, 25'h7777, 25'd0);
    check_output("ign_busy_after", 32'(busy_m), 32'd1);
    wait_finish(5000);
    check_output("ign_done", 32'(done_m), 32'd1);
    check_output("ign_words", 32'(ww_m), 32'd2);
    check_output("ign_wal", 32'(wr_addr_log[(wr_n - 1) % 1024]), 32'h41);
    check_output("ign_wdl", wr_data_log[(wr_n - 1) % 1024], 32'h4433);
    check_output("ign_nwrites", wr_n - w0, 2);

    // Reset in the middle of a transfer, then a fresh run.
    start_run(1'b0, 32'd0, 25'h60, 25'd3);
    repeat (20) @(negedge clk50);
    reset_n = 1'b0;
    @(negedge clk50);
    check_output("mid_rst_busy", 32'(busy_m), 32'd0);
    check_output("mid_rst_words", 32'(ww_m), 32'd0);
    check_output("mid_rst_we", 32'(we_m), 32'd0);
    check_output("mid_rst_ack", 32'(ack_m), 32'd0);
    repeat (2) @(negedge clk50);
    reset_n = 1'b1;
    repeat (5) @(negedge clk50);
    w0 = wr_n;
    r0 = req_n;
    start_run(1'b0, 32'd4, 25'h70, 25'd1);
    wait_finish(5000);
    check_output("post_rst_done", 32'(done_m), 32'd1);
    check_output("post_rst_nwrites", wr_n - w0, 1);
    check_output("post_rst_wa", 32'(wr_addr_log[w0 % 1024]), 32'h70);
    check_output("post_rst_wd", wr_data_log[w0 % 1024], 32'h2211);
    check_output("post_rst_addr", req_addr_log[r0 % 64], 32'd4);

    check_output("model_stall", stall_n, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
